// File: rtl/sd_dat_pkg.sv
// Shared types and constants for the SD DAT write-status path.
package sd_dat_pkg;

  typedef enum logic [2:0] {IDLE, WAIT_START, TOKEN, END_BIT, BUSY, DONE} wr_status_state_e;

  localparam logic [2:0] CrcTokenOk    = 3'b010;
  localparam logic [2:0] CrcTokenErr   = 3'b101;
  localparam logic [2:0] CrcTokenWrErr = 3'b110;
  localparam logic [3:0] TimeoutBitsMax = 4'd14;
  localparam int         TimeoutW       = 28;

  // Exponent is clamped so 4'hF cannot shift the single set bit out of 28 bits.
  function automatic logic [TimeoutW-1:0] timeout_threshold(input logic [3:0] bits);
    logic [4:0] e;
    e = (bits > TimeoutBitsMax) ? {1'b0, TimeoutBitsMax} : {1'b0, bits};
    return TimeoutW'(1) << (e + 5'd13);
  endfunction

endpackage

// File: rtl/sd_timeout_ctr.sv
// Prescaled, saturating 28-bit timeout counter with clear/enable and live threshold compare.
module sd_timeout_ctr
  import sd_dat_pkg::*;
#(
  parameter int ClockDiv = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [3:0] timeout_bits_i,
  output logic       expired_o
);
  localparam int             PreW   = (ClockDiv > 1) ? $clog2(ClockDiv) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(ClockDiv - 1);

  logic [PreW-1:0]     pre_q;
  logic [TimeoutW-1:0] cnt_q;
  logic                tick;

  assign tick = en_i && (pre_q == PreMax);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else if (en_i) begin
      pre_q <= tick ? '0 : pre_q + 1'b1;
      if (tick && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = (cnt_q >= timeout_threshold(timeout_bits_i));

endmodule

// File: rtl/sd_dat_wr_status.sv
// SD write-direction DAT0 handshake: CRC status token capture, busy wait, data timeout.
// Optional SD_DAT_BUSY_DEGLITCH_EN: busy release needs two consecutive high samples.
module sd_dat_wr_status
  import sd_dat_pkg::*;
#(
  parameter int ClockDiv = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sample_i,
  input  logic       dat0_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [3:0] timeout_bits_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [2:0] token_o,
  output logic       crc_ok_o,
  output logic       crc_err_o,
  output logic       timeout_o
);
  wr_status_state_e state_q, state_d;
  logic [1:0] bit_cnt_q;
  logic [2:0] token_q;
  logic       end_err_q, to_q;
  logic       to_set, shift, expired, tmo_clr, tmo_en, release_ok, good;

`ifdef SD_DAT_BUSY_DEGLITCH_EN
  // Tracks whether the previous sample in BUSY was already high.
  logic hi_q;
  assign release_ok = hi_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                hi_q <= 1'b0;
    else if (state_q != BUSY) hi_q <= 1'b0;
    else if (sample_i)        hi_q <= dat0_i;
  end
`else
  assign release_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    to_set  = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE:       if (start_i) state_d = WAIT_START;
      WAIT_START: begin
        if (sample_i && !dat0_i) state_d = TOKEN;
        else if (expired) begin
          state_d = DONE;
          to_set  = 1'b1;
        end
      end
      TOKEN: begin
        if (sample_i) begin
          shift = 1'b1;
          if (bit_cnt_q == 2'd2) state_d = END_BIT;
        end
      end
      END_BIT:    if (sample_i) state_d = BUSY;
      BUSY: begin
        if (sample_i && dat0_i && release_ok) state_d = DONE;
        else if (expired) begin
          state_d = DONE;
          to_set  = 1'b1;
        end
      end
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
    if (abort_i) begin
      state_d = IDLE;
      to_set  = 1'b0;
      shift   = 1'b0;
    end
  end

  // Counter is held at zero while idle and restarted on each entry to a waiting phase.
  assign tmo_en  = (state_q == WAIT_START) || (state_q == BUSY);
  assign tmo_clr = abort_i || (state_q == IDLE) ||
                   ((state_d != state_q) && ((state_d == WAIT_START) || (state_d == BUSY)));

  sd_timeout_ctr #(.ClockDiv(ClockDiv)) u_tmo (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .clr_i          (tmo_clr),
    .en_i           (tmo_en),
    .timeout_bits_i (timeout_bits_i),
    .expired_o      (expired)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      token_q   <= '0;
      end_err_q <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q != TOKEN) bit_cnt_q <= '0;
      else if (shift)       bit_cnt_q <= bit_cnt_q + 1'b1;
      if (shift) token_q <= {token_q[1:0], dat0_i};
      if (state_q == IDLE)                    end_err_q <= 1'b0;
      else if (state_q == END_BIT && sample_i) end_err_q <= !dat0_i;
      if (to_set)                to_q <= 1'b1;
      else if (state_q == IDLE)  to_q <= 1'b0;
    end
  end

  assign good      = (token_q == CrcTokenOk) && !end_err_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign token_o   = token_q;
  assign timeout_o = done_o && to_q;
  assign crc_ok_o  = done_o && !to_q && good;
  assign crc_err_o = done_o && !to_q && !good;

endmodule

// File: tb/tb_sd_dat_wr_status.sv
// Randomized self-checking bench for sd_dat_wr_status (ClockDiv=1 and ClockDiv=4 instances).
module tb_sd_dat_wr_status;
`ifdef SD_DAT_BUSY_DEGLITCH_EN
  localparam int NREL = 2;
`else
  localparam int NREL = 1;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic sample = 1'b0, dat0 = 1'b1, start = 1'b0, abort = 1'b0;
  logic [3:0] bits = 4'd0;
  logic busy1, done1, ok1, err1, to1, busy4, done4, ok4, err4, to4;
  logic [2:0] token1, token4;
  int total = 0, bad = 0;
  logic seq_bad;

  always #5 clk = ~clk;

  sd_dat_wr_status #(.ClockDiv(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .sample_i(sample), .dat0_i(dat0), .start_i(start),
    .abort_i(abort), .timeout_bits_i(bits), .busy_o(busy1), .done_o(done1),
    .token_o(token1), .crc_ok_o(ok1), .crc_err_o(err1), .timeout_o(to1));

  sd_dat_wr_status #(.ClockDiv(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .sample_i(sample), .dat0_i(dat0), .start_i(start),
    .abort_i(abort), .timeout_bits_i(bits), .busy_o(busy4), .done_o(done4),
    .token_o(token4), .crc_ok_o(ok4), .crc_err_o(err4), .timeout_o(to4));

  task automatic cyc(input logic s, input logic d);
    sample = s;
    dat0   = d;
    @(posedge clk);
    #1;
    sample = 1'b0;
  endtask

  // One cycle that must not end the handshake.
  task automatic stp(input logic s, input logic d);
    cyc(s, d);
    if (done1 !== 1'b0 || busy1 !== 1'b1) seq_bad = 1'b1;
  endtask

  // Non-sample cycles with noise on dat0 and start; both must be ignored.
  task automatic gap(input int gapmax);
    int n;
    n = (gapmax == 0) ? 0 : int'($urandom_range(gapmax, 0));
    repeat (n) begin
      start = 1'($urandom % 2);
      stp(1'b0, 1'($urandom % 2));
      start = 1'b0;
    end
  endtask

  task automatic do_abort();
    abort = 1'b1;
    cyc(1'b0, 1'b1);
    abort = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1'b0, 1'b1);
    start = 1'b0;
  endtask

  task automatic send_hdr(input logic [2:0] tok, input logic endb);
    cyc(1'b1, 1'b0);
    for (int i = 2; i >= 0; i--) cyc(1'b1, tok[i]);
    cyc(1'b1, endb);
  endtask

  task automatic txn(input logic [2:0] tok, input logic endb, input int nbusy,
                     input int gapmax, input string name);
    logic exp_ok;
    exp_ok = (tok == 3'b010) && endb;
    do_abort();
    pulse_start();
    total++;
    if (busy1 !== 1'b1) begin bad++; $display("FAIL %s busy_rise: got %b want 1", name, busy1); end
    seq_bad = 1'b0;
    repeat ($urandom_range(2, 0)) begin gap(gapmax); stp(1'b1, 1'b1); end
    gap(gapmax); stp(1'b1, 1'b0);
    for (int i = 2; i >= 0; i--) begin gap(gapmax); stp(1'b1, tok[i]); end
    gap(gapmax); stp(1'b1, endb);
    repeat (nbusy) begin gap(gapmax); stp(1'b1, 1'b0); end
    for (int r = 0; r < NREL; r++) begin
      gap(gapmax);
      if (r < NREL - 1) stp(1'b1, 1'b1);
      else cyc(1'b1, 1'b1);
    end
    total++;
    if ({done1, ok1, err1, to1} !== {1'b1, exp_ok, ~exp_ok, 1'b0}) begin
      bad++;
      $display("FAIL %s outcome: got done/ok/err/to=%b%b%b%b want 1%b%b0",
               name, done1, ok1, err1, to1, exp_ok, ~exp_ok);
    end
    total++;
    if (token1 !== tok) begin bad++; $display("FAIL %s token: got %b want %b", name, token1, tok); end
    total++;
    if (seq_bad !== 1'b0) begin bad++; $display("FAIL %s early_done_or_busy_drop: got 1 want 0", name); end
    cyc(1'b0, 1'b1);
    total++;
    if ({done1, busy1} !== 2'b00) begin bad++; $display("FAIL %s after_done: got %b want 00", name, {done1, busy1}); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy1, done1, token1, ok1, err1, to1} !== 8'h00) begin
      bad++; $display("FAIL reset_dut1: got %h want 00", {busy1, done1, token1, ok1, err1, to1});
    end
    total++;
    if ({busy4, done4, token4, ok4, err4, to4} !== 8'h00) begin
      bad++; $display("FAIL reset_dut4: got %h want 00", {busy4, done4, token4, ok4, err4, to4});
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    bits = 4'd2;
    txn(3'b010, 1'b1, 10, 0, "accepted");
    txn(3'b101, 1'b1, 3, 0, "crc_err_token");
    txn(3'b010, 1'b0, 4, 0, "end_bit_err");
  endtask

  task automatic test_random();
    logic [2:0] tok;
    logic endb;
    for (int t = 0; t < 24; t++) begin
      bits = 4'($urandom);
      if ($urandom % 2) begin tok = 3'b010; endb = 1'b1; end
      else begin tok = 3'($urandom); endb = 1'($urandom % 2); end
      txn(tok, endb, int'($urandom_range(12, 0)), 3, "random");
    end
  endtask

  task automatic test_no_start();
    int n = 0, n1 = 0, n4 = 0;
    logic [2:0] f1 = 3'b000, f4 = 3'b000;
    do_abort();
    bits = 4'd0;
    pulse_start();
    while ((n1 == 0 || n4 == 0) && n < 40000) begin
      cyc(1'b1, 1'b1);
      n++;
      if (done1 && n1 == 0) begin n1 = n; f1 = {to1, ok1, err1}; end
      if (done4 && n4 == 0) begin n4 = n; f4 = {to4, ok4, err4}; end
    end
    total++;
    if (n1 != 8193) begin bad++; $display("FAIL no_start_div1_latency: got %0d want 8193", n1); end
    total++;
    if (f1 !== 3'b100) begin bad++; $display("FAIL no_start_div1_flags: got %b want 100", f1); end
    total++;
    if (n4 != 32769) begin bad++; $display("FAIL no_start_div4_latency: got %0d want 32769", n4); end
    total++;
    if (f4 !== 3'b100) begin bad++; $display("FAIL no_start_div4_flags: got %b want 100", f4); end
  endtask

  task automatic test_stuck_busy();
    int n = 0, n1 = 0;
    logic [2:0] f1 = 3'b000;
    do_abort();
    bits = 4'd1;
    pulse_start();
    send_hdr(3'b010, 1'b1);
    while (n1 == 0 && n < 20000) begin
      cyc(1'b1, 1'b0);
      n++;
      if (done1) begin n1 = n; f1 = {to1, ok1, err1}; end
    end
    total++;
    if (n1 != 16385) begin bad++; $display("FAIL stuck_busy_latency: got %0d want 16385", n1); end
    total++;
    if (f1 !== 3'b100) begin bad++; $display("FAIL stuck_busy_flags: got %b want 100", f1); end
    // Release sample lands exactly in the expiry cycle.
    do_abort();
    pulse_start();
    send_hdr(3'b010, 1'b1);
    repeat (16384 - (NREL - 1)) cyc(1'b1, 1'b0);
    total++;
    if (done1 !== 1'b0) begin bad++; $display("FAIL tie_pre: got done=%b want 0", done1); end
    for (int r = 0; r < NREL; r++) cyc(1'b1, 1'b1);
    total++;
    if ({done1, ok1, to1} !== 3'b110) begin
      bad++; $display("FAIL tie_sample_wins: got done/ok/to=%b want 110", {done1, ok1, to1});
    end
  endtask

  task automatic test_live_bits();
    logic early = 1'b0;
    do_abort();
    bits = 4'hF;
    pulse_start();
    repeat (9000) begin
      cyc(1'b1, 1'b1);
      if (done1) early = 1'b1;
    end
    total++;
    if (early !== 1'b0) begin bad++; $display("FAIL clamp_15_no_timeout: got 1 want 0"); end
    bits = 4'd0;
    cyc(1'b1, 1'b1);
    total++;
    if ({done1, to1, ok1, err1} !== 4'b1100) begin
      bad++; $display("FAIL live_bits_expiry: got %b want 1100", {done1, to1, ok1, err1});
    end
  endtask

  task automatic test_abort();
    logic seen = 1'b0;
    do_abort();
    bits = 4'd0;
    pulse_start();
    send_hdr(3'b010, 1'b1);
    repeat (5) cyc(1'b1, 1'b0);
    abort = 1'b1;
    cyc(1'b1, 1'b1);
    abort = 1'b0;
    total++;
    if ({busy1, done1} !== 2'b00) begin bad++; $display("FAIL abort_busy: got %b want 00", {busy1, done1}); end
    repeat (5) begin
      cyc(1'b1, 1'b1);
      if (done1 || busy1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_done: got 1 want 0"); end
    abort = 1'b1;
    start = 1'b1;
    cyc(1'b0, 1'b1);
    abort = 1'b0;
    start = 1'b0;
    total++;
    if (busy1 !== 1'b0) begin bad++; $display("FAIL abort_beats_start: got %b want 0", busy1); end
    // Asynchronous reset mid-token.
    pulse_start();
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy1, done1, token1, ok1, err1, to1} !== 8'h00) begin
      bad++; $display("FAIL reset_mid_token: got %h want 00", {busy1, done1, token1, ok1, err1, to1});
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

`ifdef SD_DAT_BUSY_DEGLITCH_EN
  task automatic test_glitch();
    do_abort();
    bits = 4'd0;
    pulse_start();
    send_hdr(3'b010, 1'b1);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    total++;
    if ({done1, busy1} !== 2'b01) begin bad++; $display("FAIL glitch_ignored: got %b want 01", {done1, busy1}); end
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    total++;
    if ({done1, ok1} !== 2'b11) begin bad++; $display("FAIL glitch_release: got %b want 11", {done1, ok1}); end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_abort();
`ifdef SD_DAT_BUSY_DEGLITCH_EN
    test_glitch();
`endif
    test_live_bits();
    test_no_start();
    test_stuck_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
